ahb_dma_slv_if: RTL and testbench

- AHB-Lite slave front end for the DMA controller's register file.
- Converts CPU bus transfers into the register file's word-addressed write strobe and registered-read strobe.
- Inserts one wait state on reads to cover the register file's one-cycle read latency.
- Returns ERROR for illegal accesses.
- Sits between the AHB interconnect and the DMA register file.

---
 rtl/ahb_dma_slv_if.sv | 74 +++++++
 tb/tb_ahb_dma_slv_if.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dma_slv_if.sv
// ahb_dma_slv_if: AHB-Lite slave front end turning bus transfers into DMA register-file strobes
// Ports:
//   clk, rst (async active-low)
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA : AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP                       : AHB-Lite slave response
//   ahb_address/ahb_write_data/ahb_write_enable  : register-file write port
//   ahb_read_address/ahb_read_enable             : register-file read request
//   ahb_read_data                                : register-file read data, one cycle after the request
module ahb_dma_slv_if #(
    parameter int channel_number = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [7:0]  ahb_address,
    output logic [31:0] ahb_write_data,
    output logic        ahb_write_enable,
    output logic [7:0]  ahb_read_address,
    output logic        ahb_read_enable,
    input  logic [31:0] ahb_read_data
);
    localparam logic [8:0] N_WORDS = 9'((channel_number + 1) * 8);
    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DATA, ERR1, ERR2} state_t;
    state_t      state_q, state_d;
    logic [7:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic        eval, accept, legal, unused_bits;
    // States whose cycle ends with HREADYOUT=1 may take the next address phase.
    assign eval        = state_q inside {IDLE, WR, RD_DATA, ERR2};
    assign accept      = eval & HSEL & HREADY & HTRANS[1];
    assign legal       = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) && ({1'b0, HADDR[9:2]} < N_WORDS);
    assign unused_bits = ^{HADDR[31:10], HTRANS[0]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        if (eval)
            state_d = !accept ? IDLE : !legal ? ERR1 : HWRITE ? WR : RD_WAIT;
        else
            state_d = (state_q == RD_WAIT) ? RD_DATA : ERR2;
        // Address registers only move on a legal transfer, so they hold while the strobe is low.
        if (accept && legal && HWRITE)
            wr_addr_d = HADDR[9:2];
        if (accept && legal && !HWRITE)
            rd_addr_d = HADDR[9:2];
    end
    assign ahb_write_enable = (state_q == WR);
    assign ahb_read_enable  = (state_q == RD_WAIT);
    assign ahb_address      = wr_addr_q;
    assign ahb_read_address = rd_addr_q;
    assign ahb_write_data   = HWDATA;
    assign HREADYOUT        = !(state_q inside {RD_WAIT, ERR1});
    assign HRESP            = state_q inside {ERR1, ERR2};
    assign HRDATA           = (state_q == RD_DATA) ? ahb_read_data : '0;
endmodule

// File: tb/tb_ahb_dma_slv_if.sv
// tb_ahb_dma_slv_if: directed scoreboard bench for ahb_dma_slv_if acting as master and register file
module tb_ahb_dma_slv_if;
    localparam logic [1:0] K_W = 2'd0, K_R = 2'd1, K_E = 2'd2;
    typedef struct {
        logic [1:0]  k;
        logic [7:0]  a;
        logic [31:0] d;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata, hrdata, ahb_write_data, ahb_read_data;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hready, hreadyout, hresp;
    logic [7:0]  ahb_address, ahb_read_address;
    logic        ahb_write_enable, ahb_read_enable;
    logic [31:0] rf [0:255];
    logic [31:0] ref_mem [0:255];
    exp_t        q[$];
    int          total = 0, bad = 0, cyc = 0, rd_strobes = 0, last_n = 0;
    logic        rdy = 1'b0, prev_rd = 1'b0, err_seen = 1'b0;
    logic [31:0] pend_wd = '0;
    int          c0, s0;

    always #5 clk = ~clk;
    // Single-slave interconnect: bus HREADY is this slave's HREADYOUT.
    assign hready = hreadyout;

    ahb_dma_slv_if #(.channel_number(4)) dut (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HRDATA(hrdata), .HREADYOUT(hreadyout),
        .HRESP(hresp), .ahb_address(ahb_address), .ahb_write_data(ahb_write_data),
        .ahb_write_enable(ahb_write_enable), .ahb_read_address(ahb_read_address),
        .ahb_read_enable(ahb_read_enable), .ahb_read_data(ahb_read_data)
    );

    // Register file model with one-cycle registered read.
    always @(posedge clk) begin
        if (ahb_write_enable) rf[ahb_address] <= ahb_write_data;
        if (ahb_read_enable) ahb_read_data <= rf[ahb_read_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        if (prev_rd) begin
            chk("rd_queue", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_kind", 32'(e.k), 32'(K_R));
                chk("hrdata", hrdata, e.d);
                chk("rd_data_ready", 32'(hreadyout), 1);
            end
        end else
            chk("hrdata_zero", hrdata, 0);
        if (ahb_write_enable) begin
            chk("wr_queue", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_kind", 32'(e.k), 32'(K_W));
                chk("wr_addr", 32'(ahb_address), 32'(e.a));
                chk("wr_data", ahb_write_data, e.d);
                chk("wr_ready", 32'(hreadyout), 1);
                chk("wr_resp", 32'(hresp), 0);
            end
        end
        if (ahb_read_enable) begin
            rd_strobes++;
            chk("rs_queue", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("rs_kind", 32'(q[0].k), 32'(K_R));
                chk("rs_addr", 32'(ahb_read_address), 32'(q[0].a));
                chk("rs_wait", 32'(hreadyout), 0);
            end
        end
        if (hresp) begin
            chk("err_queue", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("err_kind", 32'(q[0].k), 32'(K_E));
                if (!hreadyout) begin
                    chk("err_first", 32'(err_seen), 0);
                    err_seen = 1'b1;
                end else begin
                    chk("err_second", 32'(err_seen), 1);
                    err_seen = 1'b0;
                    void'(q.pop_front());
                end
            end
        end else if (err_seen) begin
            chk("err_second_missing", 32'(hresp), 1);
            err_seen = 1'b0;
        end
        prev_rd = ahb_read_enable;
    endtask

    task automatic cycle();
        #1;
        rdy = hreadyout;
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents one address phase (plus the previous write's data phase) and holds it until taken.
    task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wd);
        int   n = 0;
        exp_t e;
        hsel = sel; htrans = tr; hwrite = wr; haddr = addr; hsize = sz; hwdata = pend_wd;
        do begin
            cycle();
            n++;
        end while (!rdy && n < 10);
        last_n = n;
        chk("ready_bound", 32'(rdy), 1);
        if (sel && tr[1]) begin
            e.a = addr[9:2];
            e.d = '0;
            if (sz == 3'b010 && addr[1:0] == 2'b00 && addr[9:2] < 8'd40) begin
                e.k = wr ? K_W : K_R;
                if (wr) begin
                    e.d = wd;
                    ref_mem[addr[9:2]] = wd;
                end else
                    e.d = ref_mem[addr[9:2]];
            end else
                e.k = K_E;
            q.push_back(e);
        end
        pend_wd = (sel && tr[1] && wr) ? wd : 32'h0;
    endtask

    task automatic idle();
        xfer(1'b1, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rf[i] = 32'hA000_0000 | i;
            ref_mem[i] = 32'hA000_0000 | i;
        end
        rf[8] = 32'h1234_5678;
        ref_mem[8] = 32'h1234_5678;
        rst = 1'b0; hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 3'b010; hwdata = 0;
        ahb_read_data = 0;
        #12;
        chk("rst_hreadyout", 32'(hreadyout), 1);
        chk("rst_hresp", 32'(hresp), 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_wen", 32'(ahb_write_enable), 0);
        chk("rst_ren", 32'(ahb_read_enable), 0);
        chk("rst_waddr", 32'(ahb_address), 0);
        chk("rst_raddr", 32'(ahb_read_address), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // single write then single read
        xfer(1'b1, 2'b10, 1'b1, 32'h4, 3'b010, 32'hFF);
        idle();
        xfer(1'b1, 2'b10, 1'b0, 32'h20, 3'b010, 32'h0);
        idle();
        chk("read_wait_states", 32'(last_n), 2);
        chk("waddr_hold", 32'(ahb_address), 32'h01);
        chk("raddr_hold", 32'(ahb_read_address), 32'h08);
        // write then read same address
        xfer(1'b1, 2'b10, 1'b1, 32'h8, 3'b010, 32'hCAFE_0008);
        xfer(1'b1, 2'b10, 1'b0, 32'h8, 3'b010, 32'h0);
        idle();
        // four back-to-back reads
        xfer(1'b1, 2'b10, 1'b0, 32'h40, 3'b010, 32'h0);
        c0 = cyc;
        s0 = rd_strobes;
        xfer(1'b1, 2'b11, 1'b0, 32'h44, 3'b010, 32'h0);
        xfer(1'b1, 2'b11, 1'b0, 32'h48, 3'b010, 32'h0);
        xfer(1'b1, 2'b11, 1'b0, 32'h4C, 3'b010, 32'h0);
        idle();
        chk("seq_cycles", 32'(cyc - c0), 8);
        chk("seq_strobes", 32'(rd_strobes - s0), 4);
        // illegal accesses and the last legal word
        xfer(1'b1, 2'b10, 1'b0, 32'h4, 3'b000, 32'h0);
        idle();
        xfer(1'b1, 2'b10, 1'b1, 32'h2, 3'b010, 32'h55);
        idle();
        xfer(1'b1, 2'b10, 1'b0, 32'hA0, 3'b010, 32'h0);
        idle();
        chk("err_wait_states", 32'(last_n), 2);
        xfer(1'b1, 2'b10, 1'b1, 32'h9C, 3'b010, 32'h3939_3939);
        xfer(1'b1, 2'b10, 1'b0, 32'h9C, 3'b010, 32'h0);
        idle();
        // no-transfer cases: IDLE, BUSY, deselected
        xfer(1'b1, 2'b00, 1'b1, 32'h4, 3'b010, 32'h0);
        chk("idle_zero_wait", 32'(last_n), 1);
        xfer(1'b1, 2'b01, 1'b1, 32'h4, 3'b010, 32'h0);
        chk("busy_zero_wait", 32'(last_n), 1);
        xfer(1'b0, 2'b10, 1'b1, 32'h4, 3'b010, 32'h0);
        chk("nosel_zero_wait", 32'(last_n), 1);
        idle();
        chk("nosel_resp", 32'(hresp), 0);
        // reset during RD_WAIT
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 3'b010, 32'h0);
        hsel = 1'b0; htrans = 2'b00;
        #1;
        chk("pre_rst_ren", 32'(ahb_read_enable), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_hreadyout", 32'(hreadyout), 1);
        chk("mid_rst_ren", 32'(ahb_read_enable), 0);
        chk("mid_rst_wen", 32'(ahb_write_enable), 0);
        chk("mid_rst_hrdata", hrdata, 0);
        q.delete();
        prev_rd = 1'b0;
        err_seen = 1'b0;
        pend_wd = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 3'b010, 32'h0);
        idle();
        idle();
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
